wb_mem_bridge: RTL and testbench

//  Parametrised Wishbone classic slave to synchronous-memory bridge. It accepts single
//  STB/CYC transfers and issues exactly one registered memory access per transfer.
//  It waits a configurable memory read latency, then returns a one-cycle ACK or ERR.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_addr_window.sv | 27 ++
 rtl/wb_mem_bridge.sv | 142 ++++++++++++++
 tb/tb_wb_mem_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone-to-memory bridge.
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMem  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } state_e;

  localparam int unsigned LAT_CW = 3;

  // Word-address width for a window of the given size in words; never below one bit.
  function automatic int unsigned calc_maw(input logic [63:0] words);
    if (words <= 64'd2) begin
      return 1;
    end
    return int'($clog2(words));
  endfunction

endpackage

// File: rtl/wb_addr_window.sv
// Combinational window decode: range check against [BASE_ADDR, BASE_ADDR+ADDR_SPAN)
// and conversion of the in-window byte offset to a memory word address.
module wb_addr_window #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter logic [AW-1:0] ADDR_SPAN = 'h1000,
  parameter int unsigned   MAW       = 10
) (
  input  logic [AW-1:0]  addr_i,
  output logic           hit_o,
  output logic [MAW-1:0] word_addr_o
);

  localparam int unsigned WordShift = $clog2(DW / 8);

  logic [AW:0] diff;

  // The borrow bit flags addr < BASE_ADDR; a window end past 2^AW needs no special case
  // because every offset reachable above BASE_ADDR is then already below ADDR_SPAN.
  always_comb begin
    diff        = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    hit_o       = !diff[AW] && (diff[AW-1:0] < ADDR_SPAN);
    word_addr_o = MAW'(diff[AW-1:0] >> WordShift);
  end

endmodule

// File: rtl/wb_mem_bridge.sv
// Wishbone classic slave to synchronous-memory bridge: one registered memory access per
// transfer, configurable read latency, single-cycle ACK/ERR termination.
module wb_mem_bridge
  import wb_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   MEM_LAT   = 1,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter logic [AW-1:0] ADDR_SPAN = 'h1000,
  parameter bit            ERR_EN    = 1'b1,
  localparam int unsigned  SW        = DW / 8,
  localparam int unsigned  MAW       = calc_maw(64'(ADDR_SPAN) / 64'(SW))
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [AW-1:0]  wb_addr_i,
  input  logic [DW-1:0]  wb_data_i,
  output logic [DW-1:0]  wb_data_o,
  input  logic           wb_we_i,
  input  logic           wb_stb_i,
  input  logic           wb_cyc_i,
  input  logic [SW-1:0]  wb_sel_i,
  output logic           wb_ack_o,
  output logic           wb_err_o,
  output logic [MAW-1:0] mem_addr_o,
  output logic [DW-1:0]  mem_wdata_o,
  input  logic [DW-1:0]  mem_rdata_i,
  output logic           mem_en_o,
  output logic           mem_we_o,
  output logic [SW-1:0]  mem_sel_o,
  output logic           busy_o
);

  localparam bit AsyncRead = (MEM_LAT == 0);
  localparam logic [LAT_CW-1:0] LatLoad = LAT_CW'(AsyncRead ? 0 : MEM_LAT - 1);

  state_e            state_q;
  logic [LAT_CW-1:0] lat_cnt_q;
  logic              we_q;
  logic              req;
  logic              win_hit;
  logic [MAW-1:0]    win_word;

  assign req = wb_stb_i & wb_cyc_i;

  wb_addr_window #(
    .AW       (AW),
    .DW       (DW),
    .BASE_ADDR(BASE_ADDR),
    .ADDR_SPAN(ADDR_SPAN),
    .MAW      (MAW)
  ) u_addr_window (
    .addr_i     (wb_addr_i),
    .hit_o      (win_hit),
    .word_addr_o(win_word)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      we_q        <= 1'b0;
      wb_data_o   <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_sel_o   <= '0;
      busy_o      <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless a branch below re-asserts them.
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            busy_o <= 1'b1;
            if (win_hit) begin
              state_q     <= StMem;
              we_q        <= wb_we_i;
              mem_en_o    <= 1'b1;
              mem_we_o    <= wb_we_i;
              mem_addr_o  <= win_word;
              mem_wdata_o <= wb_data_i;
              mem_sel_o   <= wb_sel_i;
            end else begin
              state_q  <= StResp;
              wb_err_o <= ERR_EN;
              wb_ack_o <= !ERR_EN;
              // No memory data exists for an out-of-window read.
              if (ERR_EN || !wb_we_i) begin
                wb_data_o <= '0;
              end
            end
          end
        end
        StMem: begin
          if (!wb_cyc_i) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end else if (we_q) begin
            state_q  <= StResp;
            wb_ack_o <= 1'b1;
          end else if (AsyncRead) begin
            state_q   <= StResp;
            wb_ack_o  <= 1'b1;
            wb_data_o <= mem_rdata_i;
          end else begin
            state_q   <= StWait;
            lat_cnt_q <= LatLoad;
          end
        end
        StWait: begin
          if (!wb_cyc_i) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end else if (lat_cnt_q == '0) begin
            state_q   <= StResp;
            wb_ack_o  <= 1'b1;
            wb_data_o <= mem_rdata_i;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Scoreboard bench for wb_mem_bridge: DUT A (MEM_LAT=3, ERR_EN=1), DUT B (MEM_LAT=2, ERR_EN=0).
module tb_wb_mem_bridge;

  typedef struct {
    bit          err;
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_addr  [2];
  logic [31:0] wb_wdata [2];
  logic [31:0] wb_rdata [2];
  logic [3:0]  wb_sel   [2];
  logic        wb_we    [2];
  logic        wb_stb   [2];
  logic        wb_cyc   [2];
  logic        wb_ack   [2];
  logic        wb_err   [2];
  logic [9:0]  mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic        mem_en   [2];
  logic        mem_we   [2];
  logic [3:0]  mem_sel  [2];
  logic        busy     [2];

  int   cycle = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   en_cnt[2] = '{0, 0};
  int   exp_en_tot[2] = '{0, 0};
  int   resp_cnt[2] = '{0, 0};
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wb_mem_bridge #(
    .AW(32), .DW(32), .MEM_LAT(3), .BASE_ADDR(32'h0), .ADDR_SPAN(32'h1000), .ERR_EN(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .wb_addr_i(wb_addr[0]), .wb_data_i(wb_wdata[0]),
    .wb_data_o(wb_rdata[0]), .wb_we_i(wb_we[0]), .wb_stb_i(wb_stb[0]), .wb_cyc_i(wb_cyc[0]),
    .wb_sel_i(wb_sel[0]), .wb_ack_o(wb_ack[0]), .wb_err_o(wb_err[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]),
    .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_sel_o(mem_sel[0]), .busy_o(busy[0])
  );

  wb_mem_bridge #(
    .AW(32), .DW(32), .MEM_LAT(2), .BASE_ADDR(32'h0), .ADDR_SPAN(32'h1000), .ERR_EN(1'b0)
  ) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .wb_addr_i(wb_addr[1]), .wb_data_i(wb_wdata[1]),
    .wb_data_o(wb_rdata[1]), .wb_we_i(wb_we[1]), .wb_stb_i(wb_stb[1]), .wb_cyc_i(wb_cyc[1]),
    .wb_sel_i(wb_sel[1]), .wb_ack_o(wb_ack[1]), .wb_err_o(wb_err[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_sel_o(mem_sel[1]), .busy_o(busy[1])
  );

  function automatic void chk(input string name, input logic [63:0] got,
                              input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endfunction

  function automatic void push_exp(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  function automatic void pop_exp(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{err: 1'b0, cyc: 0, data: 32'h0, chk: 1'b0};
    if (d == 0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); ok = 1'b1;
    end else if (d == 1 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front(); ok = 1'b1;
    end
  endfunction

  // RAM models: registered read, latency 3 for A and 2 for B; off-cycle data is poisoned.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam int L = (g == 0) ? 3 : 2;
    logic [31:0] ram [1024];
    logic [31:0] pipe[3];
    initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | i;
      ram[4] = 32'hCAFE_0001;
      ram[8] = 32'hAABB_CCDD;
      for (int i = 0; i < 3; i++) pipe[i] = 32'hBAD0_BAD0;
    end
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_sel[g][b]) ram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end
      end
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? ram[mem_addr[g]] : 32'hBAD0_BAD0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[g] = pipe[L-1];
  end

  // Response monitors: pop the expectation and compare kind, cycle and data.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial forever begin
      exp_t e;
      bit   ok;
      @(negedge clk);
      if (rst_n) begin
        if (mem_en[g]) en_cnt[g]++;
        if (wb_ack[g] || wb_err[g]) begin
          resp_cnt[g]++;
          pop_exp(g, e, ok);
          if (!ok) begin
            chk($sformatf("dut%0d unexpected_resp", g), 64'({wb_ack[g], wb_err[g]}), 64'd0);
          end else begin
            chk($sformatf("dut%0d resp_kind", g), 64'({wb_ack[g], wb_err[g]}),
                e.err ? 64'd1 : 64'd2);
            chk($sformatf("dut%0d resp_cycle", g), 64'(cycle), 64'(e.cyc));
            if (e.chk) chk($sformatf("dut%0d rdata", g), 64'(wb_rdata[g]), 64'(e.data));
          end
        end
      end
    end
  end

  function automatic logic [127:0] outs(input int d);
    return {wb_rdata[d], wb_ack[d], wb_err[d], mem_addr[d], mem_wdata[d], mem_en[d],
            mem_we[d], mem_sel[d], busy[d]};
  endfunction

  task automatic drive(input int d, input bit stb, input bit cyc_v, input bit we,
                       input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    wb_stb[d]   = stb;
    wb_cyc[d]   = cyc_v;
    wb_we[d]    = we;
    wb_addr[d]  = a;
    wb_wdata[d] = w;
    wb_sel[d]   = s;
  endtask

  // Called just after a rising edge; returns just after the edge that starts an IDLE cycle.
  task automatic xfer(input int d, input bit we, input logic [31:0] a, input logic [31:0] w,
                      input logic [3:0] s, input bit exp_err, input int lat,
                      input logic [31:0] exp_data, input bit chk_data, input bit exp_en,
                      input logic [9:0] exp_maddr);
    exp_t e;
    int   n;
    drive(d, 1'b1, 1'b1, we, a, w, s);
    e = '{err: exp_err, cyc: cycle + lat, data: exp_data, chk: chk_data};
    push_exp(d, e);
    if (exp_en) exp_en_tot[d]++;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("dut%0d mem_en@+1 a=%0h", d, a), 64'(mem_en[d]), 64'(exp_en));
    if (exp_en) begin
      chk($sformatf("dut%0d mem_we a=%0h", d, a), 64'(mem_we[d]), 64'(we));
      chk($sformatf("dut%0d mem_addr a=%0h", d, a), 64'(mem_addr[d]), 64'(exp_maddr));
      chk($sformatf("dut%0d mem_sel a=%0h", d, a), 64'(mem_sel[d]), 64'(s));
      if (we) chk($sformatf("dut%0d mem_wdata", d), 64'(mem_wdata[d]), 64'(w));
    end
    n = 0;
    while (!(wb_ack[d] || wb_err[d]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk($sformatf("dut%0d resp_timeout", d), 64'(n), 64'(lat));
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int   r;
    exp_t e;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("dut0 reset_outputs", 64'(outs(0) != '0), 64'd0);
    chk("dut1 reset_outputs", 64'(outs(1) != '0), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read-back on B; registered read on A.
    xfer(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 2, 32'h0, 1'b0, 1'b1, 10'd4);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 4, 32'hDEAD_BEEF, 1'b1, 1'b1, 10'd4);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 5, 32'hCAFE_0001, 1'b1, 1'b1, 10'd4);

    // Partial byte-select write merges into 0xAABBCCDD.
    xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 1'b0, 2, 32'h0, 1'b0, 1'b1, 10'd8);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 5, 32'hAA22_CC44, 1'b1, 1'b1, 10'd8);

    // Out-of-window: ERR with cleared data on A, plain ACK on B, no memory access on either.
    xfer(0, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 1, 32'h0, 1'b1, 1'b0, 10'd0);
    xfer(1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 1, 32'h0, 1'b0, 1'b0, 10'd0);

    // sel=0 write still pulses mem_en and ACKs, leaving the word intact.
    xfer(0, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, 1'b0, 2, 32'h0, 1'b0, 1'b1, 10'd12);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 5, 32'hA500_000C, 1'b1, 1'b1, 10'd12);

    // Abort: drop cyc in the first WAIT cycle of an A read.
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    exp_en_tot[0]++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("dut0 abort busy_in_wait", 64'(busy[0]), 64'd1);
    @(negedge clk);
    chk("dut0 abort busy_fall", 64'(busy[0]), 64'd0);
    r = resp_cnt[0];
    repeat (10) @(negedge clk);
    chk("dut0 abort no_resp", 64'(resp_cnt[0]), 64'(r));
    @(posedge clk); #1;

    // Back-to-back writes on B with stb/cyc held high: ACK every 3 cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF);
      e = '{err: 1'b0, cyc: cycle + 2, data: 32'h0, chk: 1'b0};
      push_exp(1, e);
      exp_en_tot[1]++;
      repeat (3) begin
        @(posedge clk); #1;
      end
    end
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    xfer(1, 1'b0, 32'h44, 32'h0, 4'hF, 1'b0, 4, 32'h1000_0001, 1'b1, 1'b1, 10'd17);

    // Asynchronous reset in the middle of an A read's WAIT phase.
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    exp_en_tot[0]++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("dut0 async_reset_outputs", 64'(outs(0) != '0), 64'd0);
    chk("dut1 async_reset_outputs", 64'(outs(1) != '0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 5, 32'hCAFE_0001, 1'b1, 1'b1, 10'd4);

    repeat (4) @(negedge clk);
    chk("dut0 mem_en_total", 64'(en_cnt[0]), 64'(exp_en_tot[0]));
    chk("dut1 mem_en_total", 64'(en_cnt[1]), 64'(exp_en_tot[1]));
    chk("dut0 pending_resp", 64'(exp_q0.size()), 64'd0);
    chk("dut1 pending_resp", 64'(exp_q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
